// File: rtl/sdram_pkg.sv
// Constants shared by the SDRAM loader and the SDRAM reader: frame markers,
// region base address, region sizes and the loader state encoding.
package sdram_pkg;

    localparam logic [31:0] START_WORD = 32'hF00B_F00B;
    localparam logic [31:0] STOP_WORD  = 32'hDEAD_F00B;
    localparam logic [31:0] SDRAM_ADDR = 32'h0800_0000;

    localparam int IMSIZE    = 64;
    localparam int L0SIZE    = 2048;
    localparam int L1SIZE    = 128;
    localparam int L2SIZE    = 80;
    localparam int MAX_BYTES = IMSIZE + L0SIZE + L1SIZE + L2SIZE;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_STOP,
        ST_FIN,
        ST_ERR
    } loader_state_e;

endpackage

// File: rtl/marker_window.sv
// 4-byte MSB-first shift window used to spot the start and stop markers.
// Match outputs look ahead: they compare the window as it would be after shifting in byte_i.
module marker_window
    import sdram_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       shift_i,
    input  logic       clear_i,
    input  logic [7:0] byte_i,
    output logic       match_start_o,
    output logic       match_stop_o
);

    logic [31:0] win_q;
    logic [31:0] win_d;
    logic [31:0] win_next;

    assign win_next      = {win_q[23:0], byte_i};
    assign match_start_o = (win_next == START_WORD);
    assign match_stop_o  = (win_next == STOP_WORD);

    always_comb begin
        win_d = win_q;
        if (clear_i)
            win_d = '0;
        else if (shift_i)
            win_d = win_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            win_q <= '0;
        else
            win_q <= win_d;
    end

endmodule

// File: rtl/sdram_loader.sv
// Avalon-MM write master: parses start/length/payload/stop frames from the host
// byte stream and writes the payload sequentially into SDRAM from BASE_ADDR.
module sdram_loader #(
    parameter int                             MASTER_ADDRESSWIDTH = 32,
    parameter int                             DATAWIDTH           = 8,
    parameter logic [MASTER_ADDRESSWIDTH-1:0] BASE_ADDR           = MASTER_ADDRESSWIDTH'(sdram_pkg::SDRAM_ADDR),
    parameter int                             MAX_BYTES           = sdram_pkg::MAX_BYTES,
    parameter int                             LENBITS             = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic                           abort,
    output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
    output logic [DATAWIDTH-1:0]           master_writedata,
    output logic                           master_write,
    output logic                           master_read,
    input  logic                           master_waitrequest,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [LENBITS-1:0]             bytes_written
);
    import sdram_pkg::*;

    localparam logic [LENBITS-1:0] MAX_LEN = LENBITS'(MAX_BYTES);

    loader_state_e                  state_q, state_d;
    logic [LENBITS-1:0]             len_q, len_d;
    logic [LENBITS-1:0]             rx_cnt_q, rx_cnt_d;
    logic [LENBITS-1:0]             wr_cnt_q, wr_cnt_d;
    logic [LENBITS-1:0]             bw_q, bw_d;
    logic [1:0]                     stop_cnt_q, stop_cnt_d;
    logic                           pend_q, pend_d;
    logic                           drain_q, drain_d;
    logic [DATAWIDTH-1:0]           wr_byte_q, wr_byte_d;
    logic [MASTER_ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
    logic                           busy_q;

    logic               accept;
    logic               wr_done;
    logic               win_shift;
    logic               win_clear;
    logic               match_start;
    logic               match_stop;
    logic [LENBITS-1:0] len_new;

    marker_window u_window (
        .clk          (clk),
        .reset        (reset),
        .shift_i      (win_shift),
        .clear_i      (win_clear),
        .byte_i       (s_data),
        .match_start_o(match_start),
        .match_stop_o (match_stop)
    );

    always_comb begin
        s_ready = 1'b0;
        if (!abort) begin
            case (state_q)
                ST_HUNT, ST_LEN_HI, ST_LEN_LO, ST_STOP: s_ready = 1'b1;
                ST_DATA: s_ready = !drain_q && (rx_cnt_q < len_q) &&
                                   (!pend_q || !master_waitrequest);
                default: s_ready = 1'b0;
            endcase
        end
    end

    assign accept  = s_valid && s_ready;
    assign wr_done = pend_q && !master_waitrequest;
    assign len_new = (len_q << 8) | LENBITS'(s_data);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rx_cnt_d   = rx_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        bw_d       = bw_q;
        stop_cnt_d = stop_cnt_q;
        pend_d     = pend_q;
        drain_d    = drain_q;
        wr_byte_d  = wr_byte_q;
        addr_d     = addr_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        win_shift  = 1'b0;
        win_clear  = abort;

        // Write path runs in every state so a drained write still gets counted.
        if (accept && state_q == ST_DATA) begin
            wr_byte_d = DATAWIDTH'(s_data);
            pend_d    = 1'b1;
            rx_cnt_d  = rx_cnt_q + LENBITS'(1);
        end else if (wr_done) begin
            pend_d = 1'b0;
        end
        if (wr_done) begin
            wr_cnt_d = wr_cnt_q + LENBITS'(1);
            bw_d     = bw_q + LENBITS'(1);
            addr_d   = addr_q + MASTER_ADDRESSWIDTH'(1);
        end

        case (state_q)
            ST_HUNT: begin
                if (accept) begin
                    if (match_start) begin
                        win_clear = 1'b1;
                        state_d   = ST_LEN_HI;
                    end else begin
                        win_shift = 1'b1;
                    end
                end
            end
            ST_LEN_HI: begin
                if (abort)
                    state_d = ST_HUNT;
                else if (accept) begin
                    len_d   = LENBITS'(s_data);
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (abort)
                    state_d = ST_HUNT;
                else if (accept) begin
                    len_d = len_new;
                    if (len_new == '0 || len_new > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        rx_cnt_d = '0;
                        wr_cnt_d = '0;
                        bw_d     = '0;
                        addr_d   = BASE_ADDR;
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // An issued Avalon write cannot be withdrawn: on abort, drain it first.
                if (abort || drain_q) begin
                    if (pend_d) begin
                        drain_d = 1'b1;
                    end else begin
                        drain_d = 1'b0;
                        state_d = ST_HUNT;
                    end
                end else if (wr_cnt_q == len_q && !pend_q) begin
                    stop_cnt_d = '0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (abort)
                    state_d = ST_HUNT;
                else if (accept) begin
                    stop_cnt_d = stop_cnt_q + 2'd1;
                    if (stop_cnt_q == 2'd3) begin
                        // Clear rather than keep the stop word, whose F0 0B tail would fake half a start word.
                        win_clear = 1'b1;
                        done_d    = match_stop;
                        err_d     = !match_stop;
                        state_d   = match_stop ? ST_FIN : ST_ERR;
                    end else begin
                        win_shift = 1'b1;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_HUNT;
            len_q      <= '0;
            rx_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            bw_q       <= '0;
            stop_cnt_q <= '0;
            pend_q     <= 1'b0;
            drain_q    <= 1'b0;
            wr_byte_q  <= '0;
            addr_q     <= BASE_ADDR;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rx_cnt_q   <= rx_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            bw_q       <= bw_d;
            stop_cnt_q <= stop_cnt_d;
            pend_q     <= pend_d;
            drain_q    <= drain_d;
            wr_byte_q  <= wr_byte_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= (state_d != ST_HUNT);
        end
    end

    assign master_write     = pend_q;
    assign master_address   = addr_q;
    assign master_writedata = wr_byte_q;
    assign master_read      = 1'b0;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = err_q;
    assign bytes_written    = bw_q;

endmodule

// File: tb/tb_sdram_loader.sv
// Scoreboard bench for sdram_loader: stimulus pushes expected writes/pulses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_sdram_loader;

    localparam logic [31:0] BASE = 32'h0800_0000;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        abort = 1'b0;
    logic [31:0] master_address;
    logic [7:0]  master_writedata;
    logic        master_write;
    logic        master_read;
    logic        waitreq = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] bytes_written;

    always #5 clk = ~clk;

    sdram_loader dut (
        .clk               (clk),
        .reset             (reset),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .abort             (abort),
        .master_address    (master_address),
        .master_writedata  (master_writedata),
        .master_write      (master_write),
        .master_read       (master_read),
        .master_waitrequest(waitreq),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .bytes_written     (bytes_written)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected traffic
    wr_t         exp_wr[$];
    logic [1:0]  exp_kind[$];
    int          exp_bw[$];

    task automatic push_wr(input int off, input logic [7:0] d);
        wr_t t;
        t.addr = BASE + off;
        t.data = d;
        exp_wr.push_back(t);
    endtask

    task automatic push_ev(input logic [1:0] kind, input int bw);
        exp_kind.push_back(kind);
        exp_bw.push_back(bw);
    endtask

    // Waitrequest driver: stall writes to stall_addr until total_stalled reaches stall_until
    logic [31:0] stall_addr = BASE;
    int          stall_until = 0;
    int          total_stalled = 0;
    always @(posedge clk) begin
        #1;
        if (total_stalled < stall_until && master_write && master_address == stall_addr) begin
            waitreq = 1'b1;
            total_stalled++;
        end else begin
            waitreq = 1'b0;
        end
    end

    // Monitor
    int          writes_seen = 0;
    int          stall_seen = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    wr_t         w;
    logic [1:0]  k;
    int          b;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (master_write && !waitreq) begin
                writes_seen++;
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h@%0h expected none", master_writedata, master_address);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", master_address, w.addr);
                    chk("wr_data", master_writedata, w.data);
                end
            end
            if (master_write && waitreq) begin
                stall_seen++;
                chk("stall_s_ready", s_ready, 1'b0);
                if (prev_stall) begin
                    chk("hold_addr", master_address, prev_addr);
                    chk("hold_data", master_writedata, prev_data);
                end
                prev_stall = 1'b1;
                prev_addr  = master_address;
                prev_data  = master_writedata;
            end else begin
                prev_stall = 1'b0;
            end
            if (done || error) begin
                if (exp_kind.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got done=%0b error=%0b expected none", done, error);
                end else begin
                    k = exp_kind.pop_front();
                    b = exp_bw.pop_front();
                    chk("pulse_kind", {done, error}, k);
                    if (b >= 0) chk("pulse_bytes_written", bytes_written, b);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int  n = 0;
        bit  ok = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0h not accepted, expected accept within 100 cycles", d);
        end
    endtask

    task automatic send_frame(input bq_t f);
        foreach (f[i]) send_byte(f[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    bq_t fr;
    int  ws;
    int  ss;
    int  n;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write", master_write, 1'b0);
        chk("rst_addr", master_address, BASE);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_bw", bytes_written, 16'd0);
        chk("rst_read", master_read, 1'b0);
        reset = 1'b0;
        idle(2);

        // Good 3-byte frame, no stalls
        fr = '{8'hF0, 8'h0B, 8'hF0, 8'h0B, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC,
               8'hDE, 8'hAD, 8'hF0, 8'h0B};
        ws = writes_seen;
        push_wr(0, 8'hAA); push_wr(1, 8'hBB); push_wr(2, 8'hCC);
        push_ev(2'b10, 3);
        send_frame(fr);
        chk("t1_done_latency", done, 1'b1);
        chk("t1_bw", bytes_written, 16'd3);
        idle(3);
        chk("t1_writes", writes_seen - ws, 3);

        // Same frame, BB write stalled 5 cycles
        ws = writes_seen;
        ss = stall_seen;
        stall_addr  = BASE + 1;
        stall_until = total_stalled + 5;
        push_wr(0, 8'hAA); push_wr(1, 8'hBB); push_wr(2, 8'hCC);
        push_ev(2'b10, 3);
        send_frame(fr);
        chk("t2_done_latency", done, 1'b1);
        idle(3);
        chk("t2_stall_cycles", stall_seen - ss, 5);
        chk("t2_writes", writes_seen - ws, 3);

        // Bad stop word
        fr = '{8'hF0, 8'h0B, 8'hF0, 8'h0B, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC,
               8'hDE, 8'hAD, 8'hF0, 8'h0C};
        ws = writes_seen;
        push_wr(0, 8'hAA); push_wr(1, 8'hBB); push_wr(2, 8'hCC);
        push_ev(2'b01, 3);
        send_frame(fr);
        chk("t3_error", error, 1'b1);
        chk("t3_no_done", done, 1'b0);
        idle(1);
        chk("t3_busy_after", busy, 1'b0);
        chk("t3_error_pulse", error, 1'b0);
        idle(2);
        chk("t3_writes", writes_seen - ws, 3);

        // Oversized length 2321
        fr = '{8'hF0, 8'h0B, 8'hF0, 8'h0B, 8'h09, 8'h11};
        ws = writes_seen;
        push_ev(2'b01, -1);
        send_frame(fr);
        chk("t4a_error_latency", error, 1'b1);
        idle(1);
        chk("t4a_busy_after", busy, 1'b0);
        idle(3);
        chk("t4a_no_writes", writes_seen - ws, 0);

        // Zero length
        fr = '{8'hF0, 8'h0B, 8'hF0, 8'h0B, 8'h00, 8'h00};
        push_ev(2'b01, -1);
        send_frame(fr);
        chk("t4b_error_latency", error, 1'b1);
        idle(4);
        chk("t4b_no_writes", writes_seen - ws, 0);

        // Garbage before the start word
        fr = '{8'h12, 8'h34, 8'hF0, 8'h0B, 8'hF0, 8'h0B, 8'h00, 8'h01, 8'h5A,
               8'hDE, 8'hAD, 8'hF0, 8'h0B};
        ws = writes_seen;
        push_wr(0, 8'h5A);
        push_ev(2'b10, 1);
        send_frame(fr);
        chk("t5_done", done, 1'b1);
        chk("t5_bw", bytes_written, 16'd1);
        idle(3);
        chk("t5_writes", writes_seen - ws, 1);

        // Abort while waiting for the length: byte offered with abort is refused
        fr = '{8'hF0, 8'h0B, 8'hF0, 8'h0B};
        send_frame(fr);
        chk("t6a_busy", busy, 1'b1);
        abort = 1'b1; s_valid = 1'b1; s_data = 8'h00;
        @(negedge clk);
        chk("t6a_abort_s_ready", s_ready, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b0; s_valid = 1'b0;
        chk("t6a_busy_after", busy, 1'b0);

        // Abort during a stalled DATA write: write still completes, no pulses
        ws = writes_seen;
        stall_addr  = BASE;
        stall_until = total_stalled + 6;
        fr = '{8'hF0, 8'h0B, 8'hF0, 8'h0B, 8'h00, 8'h02, 8'h11};
        push_wr(0, 8'h11);
        send_frame(fr);
        idle(1);
        abort = 1'b1; s_valid = 1'b1; s_data = 8'h22;
        @(negedge clk);
        chk("t6b_abort_s_ready", s_ready, 1'b0);
        chk("t6b_write_held", master_write, 1'b1);
        @(posedge clk);
        #1;
        abort = 1'b0; s_valid = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6b_idle", busy, 1'b0);
        idle(3);
        chk("t6b_writes", writes_seen - ws, 1);
        chk("t6b_bw", bytes_written, 16'd1);
        chk("t6b_write_low", master_write, 1'b0);

        // Recovery after abort
        fr = '{8'hF0, 8'h0B, 8'hF0, 8'h0B, 8'h00, 8'h01, 8'h77,
               8'hDE, 8'hAD, 8'hF0, 8'h0B};
        push_wr(0, 8'h77);
        push_ev(2'b10, 1);
        send_frame(fr);
        chk("t6c_done", done, 1'b1);
        idle(3);

        // Reset in the middle of a stalled DATA write
        stall_addr  = BASE;
        stall_until = total_stalled + 50;
        fr = '{8'hF0, 8'h0B, 8'hF0, 8'h0B, 8'h00, 8'h03, 8'hAA};
        send_frame(fr);
        @(negedge clk);
        chk("t7_pre_write", master_write, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_write", master_write, 1'b0);
        chk("t7_addr", master_address, BASE);
        chk("t7_busy", busy, 1'b0);
        chk("t7_bw", bytes_written, 16'd0);
        chk("t7_done", done, 1'b0);
        chk("t7_error", error, 1'b0);
        stall_until = total_stalled;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        chk("t7_write_after", master_write, 1'b0);

        chk("left_writes", exp_wr.size(), 0);
        chk("left_pulses", exp_kind.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
